prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 33 +++
 rtl/prog_loader_asm.sv | 53 +++++
 rtl/prog_loader.sv | 186 ++++++++++++++++++
 tb/tb_prog_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_pkg
// Purpose  : Shared FSM states, frame constants and field sizing helpers.
// Revision : 1.0
// ============================================================================
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_ADR = 3'd1,
    S_HDR_LEN = 3'd2,
    S_DATA    = 3'd3,
    S_WRITE   = 3'd4,
    S_CHECK   = 3'd5,
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [7:0] C_SYNC_DEFAULT = 8'hA5;

  function automatic int field_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_asm.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_asm
// Purpose  : Little-endian byte-to-word assembler with field byte counter
//            and running 8-bit checksum.
// Revision : 1.0
// ============================================================================
module prog_loader_asm #(
  parameter int BYTES = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic [CNT_W-1:0]     field_len,
  input  logic [7:0]           byte_in,
  output logic [8*BYTES-1:0]   word,
  output logic                 last,
  output logic [7:0]           sum
);

  logic [8*BYTES-1:0] r_word;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_sum;

  // The word already includes the byte being accepted, so the FSM can latch
  // a completed field on the same edge as its final byte.
  always_comb begin
    word = r_word;
    word[int'(r_cnt)*8 +: 8] = byte_in;
  end

  assign last = (r_cnt == (field_len - 1'b1));
  assign sum  = r_sum;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_sum  <= '0;
    end else if (shift_en) begin
      r_word <= word;
      r_sum  <= r_sum + byte_in;
      r_cnt  <= last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Byte-stream program loader: parses a framed image, writes it
//            through the debug memory port and releases the CPU on success.
// Revision : 1.0
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter int         LEN_W   = 16,
  parameter int         WR_HOLD = 4,
  parameter logic [7:0] SYNC    = C_SYNC_DEFAULT
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                cpu_n_reset,
  output logic                dbg_mem_op,
  output logic [ADDR_W-1:0]   dbg_adr,
  output logic [DATA_W-1:0]   dbg_do,
  output logic [DATA_W/8-1:0] dbg_wren,
  output logic                busy,
  output logic                err
);

  localparam int C_ADR_BYTES = field_bytes(ADDR_W);
  localparam int C_LEN_BYTES = field_bytes(LEN_W);
  localparam int C_DAT_BYTES = DATA_W / 8;
  localparam int C_ASM_BYTES = max3(C_ADR_BYTES, C_LEN_BYTES, C_DAT_BYTES);
  localparam int C_CNT_W     = $clog2(C_ASM_BYTES + 1);
  localparam int C_HOLD_W    = $clog2(WR_HOLD + 1);

  state_t                r_state;
  logic                  r_cpu_n_reset;
  logic                  r_mem_op;
  logic [ADDR_W-1:0]     r_adr;
  logic [DATA_W-1:0]     r_do;
  logic [DATA_W/8-1:0]   r_wren;
  logic                  r_err;
  logic [LEN_W-1:0]      r_remain;
  logic [C_HOLD_W-1:0]   r_hold;

  logic                     w_accept;
  logic                     w_is_sync;
  logic                     w_field_st;
  logic                     w_shift;
  logic                     w_clr;
  logic [C_CNT_W-1:0]       w_field_len;
  logic [8*C_ASM_BYTES-1:0] w_word;
  logic                     w_last;
  logic [7:0]               w_sum;
  logic                     w_unused_word;

  assign in_ready   = (r_state != S_WRITE);
  assign w_accept   = in_valid && in_ready;
  assign w_is_sync  = (in_data == SYNC);
  assign w_field_st = (r_state == S_HDR_ADR) || (r_state == S_HDR_LEN) || (r_state == S_DATA);
  assign w_shift    = w_accept && w_field_st;
  assign w_clr      = w_accept && w_is_sync &&
                      ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));

  always_comb begin
    w_field_len = C_CNT_W'(1);
    case (r_state)
      S_HDR_ADR: w_field_len = C_CNT_W'(C_ADR_BYTES);
      S_HDR_LEN: w_field_len = C_CNT_W'(C_LEN_BYTES);
      S_DATA:    w_field_len = C_CNT_W'(C_DAT_BYTES);
      default:   w_field_len = C_CNT_W'(1);
    endcase
  end

  prog_loader_asm #(
    .BYTES (C_ASM_BYTES),
    .CNT_W (C_CNT_W)
  ) u_asm (
    .clk       (clk),
    .n_reset   (n_reset),
    .clr       (w_clr),
    .shift_en  (w_shift),
    .field_len (w_field_len),
    .byte_in   (in_data),
    .word      (w_word),
    .last      (w_last),
    .sum       (w_sum)
  );

  // Fields narrower than the assembler leave upper bits unconsumed.
  assign w_unused_word = ^w_word;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= S_IDLE;
      r_cpu_n_reset <= 1'b0;
      r_mem_op      <= 1'b0;
      r_adr         <= '0;
      r_do          <= '0;
      r_wren        <= '0;
      r_err         <= 1'b0;
      r_remain      <= '0;
      r_hold        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_sync) begin
            r_mem_op <= 1'b1;
            r_state  <= S_HDR_ADR;
          end
        end
        S_HDR_ADR: begin
          if (w_shift && w_last) begin
            r_adr   <= w_word[ADDR_W-1:0];
            r_state <= S_HDR_LEN;
          end
        end
        S_HDR_LEN: begin
          if (w_shift && w_last) begin
            r_remain <= w_word[LEN_W-1:0];
            r_state  <= (w_word[LEN_W-1:0] == '0) ? S_CHECK : S_DATA;
          end
        end
        S_DATA: begin
          if (w_shift && w_last) begin
            r_do    <= w_word[DATA_W-1:0];
            r_wren  <= '1;
            r_hold  <= '0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_hold == C_HOLD_W'(WR_HOLD - 1)) begin
            r_wren   <= '0;
            r_adr    <= r_adr + ADDR_W'(C_DAT_BYTES);
            r_remain <= r_remain - 1'b1;
            r_state  <= (r_remain == LEN_W'(1)) ? S_CHECK : S_DATA;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_mem_op <= 1'b0;
            if (in_data == w_sum) begin
              r_cpu_n_reset <= 1'b1;
              r_state       <= S_RUN;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        S_RUN: begin
          if (w_accept && w_is_sync) begin
            r_cpu_n_reset <= 1'b0;
            r_mem_op      <= 1'b1;
            r_state       <= S_HDR_ADR;
          end
        end
        S_ERROR: begin
          if (w_accept && w_is_sync) begin
            r_err    <= 1'b0;
            r_mem_op <= 1'b1;
            r_state  <= S_HDR_ADR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_n_reset = r_cpu_n_reset;
  assign dbg_mem_op  = r_mem_op;
  assign dbg_adr     = r_adr;
  assign dbg_do      = r_do;
  assign dbg_wren    = r_wren;
  assign err         = r_err;
  assign busy        = (r_state == S_HDR_ADR) || (r_state == S_HDR_LEN) ||
                       (r_state == S_DATA)    || (r_state == S_WRITE)   ||
                       (r_state == S_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Directed frames with a write scoreboard for prog_loader.
// Revision : 1.0
// ============================================================================
module tb_prog_loader;

  localparam int         WR_HOLD = 4;
  localparam logic [7:0] SYNC_B  = 8'hA5;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [3:0]  dbg_wren;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W (32), .DATA_W (32), .LEN_W (16), .WR_HOLD (WR_HOLD), .SYNC (SYNC_B)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cpu_n_reset (cpu_n_reset),
    .dbg_mem_op  (dbg_mem_op),
    .dbg_adr     (dbg_adr),
    .dbg_do      (dbg_do),
    .dbg_wren    (dbg_wren),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] wbuf [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed write pulse is checked against the queue head.
  bit          m_active = 0;
  int          m_hold;
  bit          m_stable;
  bit          m_memop;
  logic [31:0] m_adr;
  logic [31:0] m_dat;

  always @(negedge clk) begin
    if (!n_reset) begin
      m_active = 0;
    end else if (dbg_wren != 4'h0) begin
      if (!m_active) begin
        m_active = 1;
        m_hold   = 1;
        m_adr    = dbg_adr;
        m_dat    = dbg_do;
        m_stable = (dbg_wren == 4'hF);
        m_memop  = dbg_mem_op;
      end else begin
        m_hold++;
        if (dbg_adr !== m_adr || dbg_do !== m_dat || dbg_wren !== 4'hF) m_stable = 0;
        if (!dbg_mem_op) m_memop = 0;
      end
    end else if (m_active) begin
      wr_t e;
      m_active = 0;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {32'h0, m_adr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_adr", m_adr, e.adr);
        chk("wr_dat", m_dat, e.dat);
        chk("wr_hold", m_hold, WR_HOLD);
        chk("wr_stable", m_stable, 1);
        chk("wr_memop", m_memop, 1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] base, input int len, input int nsend,
                            input logic [7:0] cks_off, input bit with_sync, input int npush);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [15:0] l16;
    logic [31:0] w;
    wr_t         e;
    sum = 8'h00;
    l16 = 16'(len);
    if (with_sync) send_byte(SYNC_B);
    for (int i = 0; i < 4; i++) begin
      b = base[8*i +: 8];
      sum = sum + b;
      send_byte(b);
    end
    for (int i = 0; i < 2; i++) begin
      b = l16[8*i +: 8];
      sum = sum + b;
      send_byte(b);
    end
    for (int k = 0; k < nsend; k++) begin
      w = wbuf[k];
      if (k < npush) begin
        e.adr = base + 32'(4 * k);
        e.dat = w;
        exp_q.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
        b = w[8*i +: 8];
        sum = sum + b;
        send_byte(b);
      end
    end
    if (nsend == len) send_byte(sum + cks_off);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || m_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 2000, 1);
  endtask

  task automatic load_prog_a();
    wbuf[0] = 32'h00010137; wbuf[1] = 32'hff010113; wbuf[2] = 32'h00020537;
    wbuf[3] = 32'h08850513; wbuf[4] = 32'h00a12623; wbuf[5] = 32'h00c12583;
    wbuf[6] = 32'h0000006f;
  endtask

  initial begin
    n_reset  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_n_reset", cpu_n_reset, 0);
    chk("rst_mem_op", dbg_mem_op, 0);
    chk("rst_wren", dbg_wren, 0);
    chk("rst_adr", dbg_adr, 0);
    chk("rst_do", dbg_do, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    n_reset = 1'b1;
    @(negedge clk);

    // Non-SYNC bytes in IDLE are discarded.
    send_byte(8'h33);
    send_byte(8'h5A);
    in_valid = 1'b0;
    chk("idle_discard_busy", busy, 0);
    chk("idle_discard_memop", dbg_mem_op, 0);

    // Good image at 0x20000: 7 writes, then boot.
    load_prog_a();
    send_frame(32'h0002_0000, 7, 7, 8'h00, 1'b1, 7);
    wait_idle();
    chk("a_cpu_run", cpu_n_reset, 1);
    chk("a_err", err, 0);
    chk("a_memop_off", dbg_mem_op, 0);

    // SYNC in RUN drops the CPU reset on the accepting edge.
    send_byte(SYNC_B);
    chk("reload_cpu_reset", cpu_n_reset, 0);
    chk("reload_busy", busy, 1);
    chk("reload_memop", dbg_mem_op, 1);
    // Same image, checksum off by one: writes still happen, then error.
    send_frame(32'h0002_0000, 7, 7, 8'h01, 1'b0, 7);
    wait_idle();
    chk("bad_err", err, 1);
    chk("bad_cpu_held", cpu_n_reset, 0);
    chk("bad_memop_off", dbg_mem_op, 0);

    // SYNC clears err; empty image at 0x100 boots without any write.
    send_byte(SYNC_B);
    chk("err_cleared", err, 0);
    send_frame(32'h0000_0100, 0, 0, 8'h00, 1'b0, 0);
    wait_idle();
    chk("len0_cpu_run", cpu_n_reset, 1);
    chk("len0_err", err, 0);

    // Address wraps modulo 2^32.
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788;
    send_frame(32'hFFFF_FFFC, 2, 2, 8'h00, 1'b1, 2);
    wait_idle();
    chk("wrap_cpu_run", cpu_n_reset, 1);

    // Reset during the second write: only the first write completes.
    wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1; wbuf[2] = 32'hC2C2C2C2;
    send_frame(32'h0000_0300, 3, 2, 8'h00, 1'b1, 1);
    chk("mid_in_write", dbg_wren, 4'hF);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_wren", dbg_wren, 0);
    chk("mid_rst_adr", dbg_adr, 0);
    chk("mid_rst_do", dbg_do, 0);
    chk("mid_rst_memop", dbg_mem_op, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpu", cpu_n_reset, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    chk("mid_rst_q_empty", exp_q.size(), 0);
    send_byte(8'h77);
    in_valid = 1'b0;
    chk("post_rst_discard", busy, 0);
    wbuf[0] = 32'hDEADBEEF;
    send_frame(32'h0000_0400, 1, 1, 8'h00, 1'b1, 1);
    wait_idle();
    chk("fresh_cpu_run", cpu_n_reset, 1);
    chk("fresh_err", err, 0);

    repeat (WR_HOLD + 4) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
